rs_load_param: RTL and testbench
================================

RS_LOAD_PARAM -- requirements
Module: rs_load_param

Interface
REQ-001 Parameter DEPTH, default 3, number of load entries (2..8).
REQ-002 Parameter DATA_W, default 64, operand/offset/address width.
REQ-003 Parameter TAG_W, default 4, tag width; tag value 0 means "no tag".
REQ-004 Parameter TAG_BASE, default 6, tag of entry 0; entry i owns tag TAG_BASE+i.
REQ-005 Clock and reset SHALL be one clock and an asynchronous, active-low reset.
REQ-006 clk  in  1  sole clock, rising edge.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 iss_valid  in  1  dispatcher presents a load.
REQ-009 iss_ready  out  1  at least one entry FREE.
REQ-010 iss_vj  in  DATA_W  base operand value.
REQ-011 iss_qj  in  TAG_W  producer tag of base; 0 = value valid.
REQ-012 iss_offset  in  DATA_W  immediate offset.
REQ-013 iss_tag  out  TAG_W  tag the next accepted load receives; 0 when full.
REQ-014 cdb_valid  in  1  CDB broadcast valid.
REQ-015 cdb_tag  in  TAG_W  broadcasting producer tag.
REQ-016 cdb_data  in  DATA_W  broadcast value.
REQ-017 mem_valid  out  1  load request to memory unit.
REQ-018 mem_ready  in  1  memory unit accepts request.
REQ-019 mem_addr  out  DATA_W  effective address.
REQ-020 mem_tag  out  TAG_W  tag of requesting entry.
REQ-021 free_valid  in  1  release an entry.
REQ-022 free_tag  in  TAG_W  tag to release.
REQ-023 busy  out  1  all entries non-FREE.
REQ-024 count  out  clog2(DEPTH+1)  number of non-FREE entries.

Function
REQ-025 Each entry SHALL hold state FREE, WAIT_OP, ADDR, READY or ISSUED, plus op, qj, offset, addr and an issue-order age.
REQ-026 Issue SHALL occur on a clk edge with iss_valid && iss_ready, into the lowest-index FREE entry; iss_tag SHALL equal TAG_BASE + that index.
REQ-027 On issue the entry SHALL go to ADDR if iss_qj==0 or (cdb_valid && cdb_tag==iss_qj), capturing cdb_data in the latter case, else to WAIT_OP.
REQ-028 WAIT_OP SHALL go to ADDR on cdb_valid && cdb_tag==qj, capturing cdb_data and clearing qj; cdb_tag 0 SHALL be ignored.
REQ-029 ADDR SHALL go to READY after exactly one cycle with addr = op + offset, truncated to DATA_W (wrap-around, no flag).
REQ-030 mem_valid SHALL be high whenever any entry is READY; the oldest READY entry by issue order SHALL be selected.
REQ-031 Once mem_valid is high, mem_addr and mem_tag SHALL stay stable until mem_valid && mem_ready, even if an older entry becomes READY.
REQ-032 On mem_valid && mem_ready the selected entry SHALL go to ISSUED; the next request SHALL appear no earlier than the following cycle.
REQ-033 free_valid with free_tag in [TAG_BASE, TAG_BASE+DEPTH-1] SHALL return that entry to FREE from any state (squash allowed); out-of-range tags SHALL be ignored.
REQ-034 If a freed entry is currently presented and mem_ready is low, mem_valid SHALL drop (or switch to another READY entry) next cycle.
REQ-035 iss_ready, busy and count SHALL be derived from registered state only; an entry freed this cycle SHALL be issuable from the next cycle.
REQ-036 Simultaneous issue and free of different entries in one cycle SHALL both take effect; count SHALL change by net +0.
REQ-037 Issue when iss_ready is low SHALL be ignored with no state change.
REQ-038 Age order SHALL remain correct after arbitrary frees and reissues; no starvation of a READY entry.

Reset
REQ-039 While rst_n is low all entries SHALL be FREE; mem_valid=0, mem_addr=0, mem_tag=0, busy=0, count=0, iss_ready=1, iss_tag=TAG_BASE.
REQ-040 Reset mid-operation SHALL discard all entries and any pending request immediately, without waiting for clk.

Verification
REQ-041 Issue vj=0x100, qj=0, offset=0x8 -> ADDR, then mem_valid=1, mem_addr=0x108, mem_tag=6 two cycles after issue.
REQ-042 Issue qj=3 into entry 0; cdb_valid, cdb_tag=3, cdb_data=0x2000 two cycles later -> mem_addr=0x2000+offset, mem_tag=6; same-cycle CDB on issue also captured.
REQ-043 Fill 3 entries -> busy=1, iss_ready=0, iss_tag=0, count=3; extra issue ignored; free_tag=7 -> next cycle iss_tag=7, busy=0.
REQ-044 Tags 6,7 READY with 7 older (reissued order), mem_ready=0 for 3 cycles -> mem_tag stays 7, mem_addr stable; mem_ready=1 -> then 6 presented.
REQ-045 vj=0xFFFF_FFFF_FFFF_FFF8, offset=0x10 -> mem_addr=0x8.
REQ-046 Assert rst_n=0 asynchronously while mem_valid=1 -> mem_valid=0, count=0 before the next clk edge.

Source files
------------

// File: rtl/rs_load_param.sv
// Load reservation station: holds loads until their base operand is
// known, forms the effective address, and presents the oldest ready one.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   iss_*                 load issue from the dispatcher; iss_tag is the
//                         tag the next accepted load gets (0 when full)
//   cdb_*                 common data bus broadcast (tag 0 ignored)
//   mem_*                 request to the memory unit, valid/ready
//   free_valid, free_tag  release (or squash) an entry by tag
//   busy, count           occupancy, derived from registered state
module rs_load_param #(
  parameter int DEPTH    = 3,
  parameter int DATA_W   = 64,
  parameter int TAG_W    = 4,
  parameter int TAG_BASE = 6
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       iss_valid,
  output logic                       iss_ready,
  input  logic [DATA_W-1:0]          iss_vj,
  input  logic [TAG_W-1:0]           iss_qj,
  input  logic [DATA_W-1:0]          iss_offset,
  output logic [TAG_W-1:0]           iss_tag,
  input  logic                       cdb_valid,
  input  logic [TAG_W-1:0]           cdb_tag,
  input  logic [DATA_W-1:0]          cdb_data,
  output logic                       mem_valid,
  input  logic                       mem_ready,
  output logic [DATA_W-1:0]          mem_addr,
  output logic [TAG_W-1:0]           mem_tag,
  input  logic                       free_valid,
  input  logic [TAG_W-1:0]           free_tag,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef enum logic [2:0] {
    S_FREE,
    S_WAIT,
    S_ADDR,
    S_READY,
    S_ISSUED
  } st_t;

  st_t               st_q   [DEPTH];
  st_t               st_d   [DEPTH];
  logic [DATA_W-1:0] op_q   [DEPTH];
  logic [DATA_W-1:0] op_d   [DEPTH];
  logic [DATA_W-1:0] off_q  [DEPTH];
  logic [DATA_W-1:0] off_d  [DEPTH];
  logic [DATA_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] addr_d [DEPTH];
  logic [TAG_W-1:0]  qj_q   [DEPTH];
  logic [TAG_W-1:0]  qj_d   [DEPTH];

  // old_q[j][i] set means entry j was issued before entry i.
  // A new entry clears its row and sets its column, so rows of
  // freed entries may go stale without affecting live ones.
  logic [DEPTH-1:0]  old_q  [DEPTH];
  logic [DEPTH-1:0]  old_d  [DEPTH];

  // Holds the presented entry until the memory unit takes it.
  logic              lock_q;
  logic              lock_d;
  logic [IW-1:0]     lock_idx_q;
  logic [IW-1:0]     lock_idx_d;

  logic [DEPTH-1:0]  free_m;
  logic [DEPTH-1:0]  rdy_m;
  logic [DEPTH-1:0]  oldest_m;
  logic              have_free;
  logic [IW-1:0]     iss_idx;
  logic [IW-1:0]     oldest_idx;
  logic [IW-1:0]     sel_idx;
  logic [CW-1:0]     cnt;
  logic              iss_fire;
  logic              mem_fire;
  logic              iss_cdb_hit;
  logic              fr_ok;
  logic [IW-1:0]     fr_idx;

  always_comb begin : scan_p
    have_free  = 1'b0;
    iss_idx    = '0;
    oldest_idx = '0;
    cnt        = '0;
    free_m     = '0;
    rdy_m      = '0;
    oldest_m   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      free_m[i] = (st_q[i] == S_FREE);
      rdy_m[i]  = (st_q[i] == S_READY);
      cnt       = cnt + CW'(!free_m[i]);
    end
    for (int i = 0; i < DEPTH; i++) begin
      oldest_m[i] = rdy_m[i];
      for (int j = 0; j < DEPTH; j++) begin
        if (j != i && rdy_m[j] && old_q[j][i])
          oldest_m[i] = 1'b0;
      end
    end
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (free_m[i]) begin
        have_free = 1'b1;
        iss_idx   = IW'(i);
      end
      if (oldest_m[i])
        oldest_idx = IW'(i);
    end
  end

  assign sel_idx = (lock_q && rdy_m[lock_idx_q]) ? lock_idx_q
                                                 : oldest_idx;

  assign iss_ready = have_free;
  assign busy      = !have_free;
  assign count     = cnt;
  assign iss_tag   = have_free
                   ? TAG_W'(TAG_BASE + int'(iss_idx))
                   : '0;

  assign mem_valid = |rdy_m;
  assign mem_addr  = mem_valid ? addr_q[sel_idx] : '0;
  assign mem_tag   = mem_valid
                   ? TAG_W'(TAG_BASE + int'(sel_idx))
                   : '0;

  assign iss_fire    = iss_valid && have_free;
  assign mem_fire    = mem_valid && mem_ready;
  assign iss_cdb_hit = cdb_valid && (cdb_tag != '0)
                    && (cdb_tag == iss_qj);

  assign fr_ok  = free_valid
               && (int'(free_tag) >= TAG_BASE)
               && (int'(free_tag) < TAG_BASE + DEPTH);
  assign fr_idx = IW'(int'(free_tag) - TAG_BASE);

  always_comb begin : next_p
    lock_d     = mem_valid && !mem_ready;
    lock_idx_d = sel_idx;
    for (int i = 0; i < DEPTH; i++) begin
      st_d[i]   = st_q[i];
      op_d[i]   = op_q[i];
      off_d[i]  = off_q[i];
      addr_d[i] = addr_q[i];
      qj_d[i]   = qj_q[i];
      old_d[i]  = old_q[i];
    end
    for (int i = 0; i < DEPTH; i++) begin
      unique case (st_q[i])
        S_WAIT: begin
          if (cdb_valid && cdb_tag != '0
              && cdb_tag == qj_q[i]) begin
            op_d[i] = cdb_data;
            qj_d[i] = '0;
            st_d[i] = S_ADDR;
          end
        end
        S_ADDR: begin
          addr_d[i] = op_q[i] + off_q[i];
          st_d[i]   = S_READY;
        end
        S_READY: begin
          if (mem_fire && sel_idx == IW'(i))
            st_d[i] = S_ISSUED;
        end
        default: ;
      endcase
      if (fr_ok && fr_idx == IW'(i) && !free_m[i]) begin
        st_d[i] = S_FREE;
        qj_d[i] = '0;
      end
      if (iss_fire && iss_idx == IW'(i)) begin
        op_d[i]  = iss_vj;
        off_d[i] = iss_offset;
        qj_d[i]  = iss_qj;
        st_d[i]  = S_WAIT;
        unique case (1'b1)
          (iss_qj == '0): begin
            st_d[i] = S_ADDR;
          end
          iss_cdb_hit: begin
            op_d[i] = cdb_data;
            qj_d[i] = '0;
            st_d[i] = S_ADDR;
          end
          default: ;
        endcase
        old_d[i] = '0;
        for (int j = 0; j < DEPTH; j++) begin
          if (j != i)
            old_d[j][i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        st_q[i]   <= S_FREE;
        op_q[i]   <= '0;
        off_q[i]  <= '0;
        addr_q[i] <= '0;
        qj_q[i]   <= '0;
        old_q[i]  <= '0;
      end
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        st_q[i]   <= st_d[i];
        op_q[i]   <= op_d[i];
        off_q[i]  <= off_d[i];
        addr_q[i] <= addr_d[i];
        qj_q[i]   <= qj_d[i];
        old_q[i]  <= old_d[i];
      end
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
    end
  end

endmodule

// File: tb/tb_rs_load_param.sv
// Bench for rs_load_param: directed steps plus random traffic,
// every cycle compared with a sequence-number based reference model.
module tb_rs_load_param;

  localparam int D  = 3;
  localparam int TB = 6;

  localparam int M_FREE  = 0;
  localparam int M_WAIT  = 1;
  localparam int M_ADDR  = 2;
  localparam int M_READY = 3;
  localparam int M_ISS   = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        iss_valid;
  logic        iss_ready;
  logic [63:0] iss_vj;
  logic [3:0]  iss_qj;
  logic [63:0] iss_offset;
  logic [3:0]  iss_tag;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [63:0] cdb_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [63:0] mem_addr;
  logic [3:0]  mem_tag;
  logic        free_valid;
  logic [3:0]  free_tag;
  logic        busy;
  logic [1:0]  count;

  int ncmp = 0;
  int nfail = 0;

  rs_load_param dut (
    .clk(clk),
    .rst_n(rst_n),
    .iss_valid(iss_valid),
    .iss_ready(iss_ready),
    .iss_vj(iss_vj),
    .iss_qj(iss_qj),
    .iss_offset(iss_offset),
    .iss_tag(iss_tag),
    .cdb_valid(cdb_valid),
    .cdb_tag(cdb_tag),
    .cdb_data(cdb_data),
    .mem_valid(mem_valid),
    .mem_ready(mem_ready),
    .mem_addr(mem_addr),
    .mem_tag(mem_tag),
    .free_valid(free_valid),
    .free_tag(free_tag),
    .busy(busy),
    .count(count)
  );

  always #5 clk = ~clk;

  int          m_st   [D];
  logic [63:0] m_op   [D];
  logic [63:0] m_off  [D];
  logic [63:0] m_addr [D];
  logic [3:0]  m_qj   [D];
  int          m_seq  [D];
  int          seqc;
  int          m_lock;

  function automatic int m_sel();
    int best;
    best = -1;
    if (m_lock >= 0 && m_st[m_lock] == M_READY)
      return m_lock;
    for (int i = 0; i < D; i++)
      if (m_st[i] == M_READY
          && (best < 0 || m_seq[i] < m_seq[best]))
        best = i;
    return best;
  endfunction

  function automatic int m_fi();
    for (int i = 0; i < D; i++)
      if (m_st[i] == M_FREE) return i;
    return -1;
  endfunction

  function automatic int m_cnt();
    int c;
    c = 0;
    for (int i = 0; i < D; i++)
      if (m_st[i] != M_FREE) c++;
    return c;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < D; i++) begin
      m_st[i]   = M_FREE;
      m_op[i]   = '0;
      m_off[i]  = '0;
      m_addr[i] = '0;
      m_qj[i]   = '0;
      m_seq[i]  = 0;
    end
    seqc   = 0;
    m_lock = -1;
  endtask

  task automatic m_step();
    int sel;
    int fi;
    int k;
    int n_st [D];
    sel = m_sel();
    fi  = m_fi();
    for (int i = 0; i < D; i++) n_st[i] = m_st[i];
    for (int i = 0; i < D; i++) begin
      if (m_st[i] == M_WAIT && cdb_valid && cdb_tag != 0
          && cdb_tag == m_qj[i]) begin
        m_op[i] = cdb_data;
        m_qj[i] = 0;
        n_st[i] = M_ADDR;
      end else if (m_st[i] == M_ADDR) begin
        m_addr[i] = m_op[i] + m_off[i];
        n_st[i]   = M_READY;
      end else if (m_st[i] == M_READY && sel == i && mem_ready) begin
        n_st[i] = M_ISS;
      end
    end
    if (free_valid && free_tag >= TB && free_tag < TB + D) begin
      k = int'(free_tag) - TB;
      if (m_st[k] != M_FREE) begin
        n_st[k] = M_FREE;
        m_qj[k] = 0;
      end
    end
    if (iss_valid && fi >= 0) begin
      m_op[fi]  = iss_vj;
      m_off[fi] = iss_offset;
      m_seq[fi] = seqc;
      seqc++;
      if (iss_qj == 0) begin
        m_qj[fi] = 0;
        n_st[fi] = M_ADDR;
      end else if (cdb_valid && cdb_tag == iss_qj) begin
        m_op[fi] = cdb_data;
        m_qj[fi] = 0;
        n_st[fi] = M_ADDR;
      end else begin
        m_qj[fi] = iss_qj;
        n_st[fi] = M_WAIT;
      end
    end
    m_lock = (sel >= 0 && !mem_ready) ? sel : -1;
    for (int i = 0; i < D; i++) m_st[i] = n_st[i];
  endtask

  task automatic chk(input string nm, input string sig,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s.%s observed=%h expected=%h",
             nm, sig, got, exp);
    end
  endtask

  task automatic check_model(input string nm);
    int sel;
    int fi;
    sel = m_sel();
    fi  = m_fi();
    chk(nm, "iss_ready", iss_ready, fi >= 0);
    chk(nm, "iss_tag", iss_tag, fi >= 0 ? 64'(TB + fi) : 64'd0);
    chk(nm, "busy", busy, fi < 0);
    chk(nm, "count", count, 64'(m_cnt()));
    chk(nm, "mem_valid", mem_valid, sel >= 0);
    chk(nm, "mem_addr", mem_addr, sel >= 0 ? m_addr[sel] : 64'd0);
    chk(nm, "mem_tag", mem_tag, sel >= 0 ? 64'(TB + sel) : 64'd0);
  endtask

  task automatic cyc(input string nm);
    m_step();
    @(posedge clk);
    #1;
    check_model(nm);
  endtask

  task automatic idle();
    iss_valid  = 0;
    iss_vj     = 0;
    iss_qj     = 0;
    iss_offset = 0;
    cdb_valid  = 0;
    cdb_tag    = 0;
    cdb_data   = 0;
    mem_ready  = 0;
    free_valid = 0;
    free_tag   = 0;
  endtask

  task automatic put_iss(input logic [63:0] vj,
                         input logic [3:0] qj,
                         input logic [63:0] off);
    iss_valid  = 1;
    iss_vj     = vj;
    iss_qj     = qj;
    iss_offset = off;
  endtask

  task automatic put_cdb(input logic [3:0] t, input logic [63:0] d);
    cdb_valid = 1;
    cdb_tag   = t;
    cdb_data  = d;
  endtask

  task automatic put_free(input logic [3:0] t);
    free_valid = 1;
    free_tag   = t;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    m_reset();
    @(posedge clk);
    #1;
    chk("rst", "mem_valid", mem_valid, 0);
    chk("rst", "mem_addr", mem_addr, 0);
    chk("rst", "mem_tag", mem_tag, 0);
    chk("rst", "busy", busy, 0);
    chk("rst", "count", count, 0);
    chk("rst", "iss_ready", iss_ready, 1);
    chk("rst", "iss_tag", iss_tag, 6);
    rst_n = 1;

    // simple ready operand
    put_iss(64'h100, 0, 64'h8); cyc("b0"); idle();
    chk("b0", "mem_valid", mem_valid, 0);
    cyc("b1");
    chk("b1", "mem_valid", mem_valid, 1);
    chk("b1", "mem_addr", mem_addr, 64'h108);
    chk("b1", "mem_tag", mem_tag, 6);
    mem_ready = 1; cyc("b2"); idle();
    chk("b2", "mem_valid", mem_valid, 0);
    put_free(6); cyc("b3"); idle();
    chk("b3", "count", count, 0);

    // operand from CDB two cycles later, then same-cycle capture
    put_iss(64'h55, 3, 64'h10); cyc("c0"); idle();
    cyc("c1");
    chk("c1", "mem_valid", mem_valid, 0);
    put_cdb(3, 64'h2000); cyc("c2"); idle();
    cyc("c3");
    chk("c3", "mem_addr", mem_addr, 64'h2010);
    chk("c3", "mem_tag", mem_tag, 6);
    put_iss(64'h77, 5, 64'h4); put_cdb(5, 64'h3000);
    cyc("c4"); idle();
    cyc("c5");
    chk("c5", "mem_tag", mem_tag, 6);
    mem_ready = 1; cyc("c6");
    chk("c6", "mem_tag", mem_tag, 7);
    chk("c6", "mem_addr", mem_addr, 64'h3004);
    cyc("c7"); idle();
    chk("c7", "mem_valid", mem_valid, 0);
    put_free(6); cyc("c8"); idle();
    put_free(7); cyc("c9"); idle();

    // fill, overflow, free, out-of-range free, issue+free
    for (int k = 0; k < 3; k++) begin
      put_iss(64'(k), 9, 64'(k)); cyc("fill"); idle();
    end
    chk("full", "busy", busy, 1);
    chk("full", "iss_ready", iss_ready, 0);
    chk("full", "iss_tag", iss_tag, 0);
    chk("full", "count", count, 3);
    put_iss(64'hdead, 0, 0); cyc("extra"); idle();
    chk("extra", "count", count, 3);
    put_free(7); cyc("fr7"); idle();
    chk("fr7", "iss_tag", iss_tag, 7);
    chk("fr7", "busy", busy, 0);
    chk("fr7", "count", count, 2);
    put_free(9); cyc("oor9"); idle();
    chk("oor9", "count", count, 2);
    put_free(5); cyc("oor5"); idle();
    chk("oor5", "count", count, 2);
    put_iss(64'h1, 9, 0); put_free(6); cyc("simul"); idle();
    chk("simul", "count", count, 2);
    chk("simul", "iss_tag", iss_tag, 6);
    put_free(7); cyc("d0"); idle();
    put_free(8); cyc("d1"); idle();
    chk("d1", "count", count, 0);

    // tag 7 older than reissued tag 6, held while mem_ready low
    put_iss(64'h1, 9, 0); cyc("e0"); idle();
    put_iss(64'h2, 9, 64'h20); cyc("e1"); idle();
    put_free(6); cyc("e2"); idle();
    put_iss(64'h6000, 0, 64'h8); put_cdb(9, 64'h7700);
    cyc("e3"); idle();
    cyc("e4");
    chk("e4", "mem_tag", mem_tag, 7);
    chk("e4", "mem_addr", mem_addr, 64'h7720);
    for (int k = 0; k < 3; k++) begin
      cyc("hold");
      chk("hold", "mem_tag", mem_tag, 7);
      chk("hold", "mem_addr", mem_addr, 64'h7720);
    end
    mem_ready = 1; cyc("e5");
    chk("e5", "mem_tag", mem_tag, 6);
    chk("e5", "mem_addr", mem_addr, 64'h6008);
    cyc("e6"); idle();
    put_free(6); cyc("e7"); idle();
    put_free(7); cyc("e8"); idle();

    // older entry turning ready must not displace a presented one
    put_iss(64'h10, 9, 0); cyc("l0"); idle();
    put_iss(64'h20, 0, 0); cyc("l1"); idle();
    cyc("l2");
    chk("l2", "mem_tag", mem_tag, 7);
    put_cdb(9, 64'h50); cyc("l3"); idle();
    cyc("l4");
    chk("l4", "mem_tag", mem_tag, 7);
    chk("l4", "mem_addr", mem_addr, 64'h20);
    mem_ready = 1; cyc("l5"); idle();
    chk("l5", "mem_tag", mem_tag, 6);
    chk("l5", "mem_addr", mem_addr, 64'h50);
    cyc("l6");
    put_free(6); cyc("l7"); idle();
    chk("l7", "mem_valid", mem_valid, 0);
    put_free(7); cyc("l8"); idle();

    // address wrap-around
    put_iss(64'hFFFF_FFFF_FFFF_FFF8, 0, 64'h10); cyc("w0"); idle();
    cyc("w1");
    chk("w1", "mem_addr", mem_addr, 64'h8);
    put_free(6); cyc("w2"); idle();

    // random traffic
    for (int n = 0; n < 600; n++) begin
      iss_valid  = ($urandom_range(0, 99) < 50);
      iss_vj     = {$urandom, $urandom};
      iss_qj     = ($urandom_range(0, 2) == 0)
                 ? 4'd0 : 4'($urandom_range(1, 15));
      iss_offset = {$urandom, $urandom};
      cdb_valid  = ($urandom_range(0, 99) < 40);
      cdb_tag    = 4'($urandom_range(0, 15));
      cdb_data   = {$urandom, $urandom};
      mem_ready  = ($urandom_range(0, 99) < 40);
      free_valid = ($urandom_range(0, 99) < 30);
      free_tag   = 4'($urandom_range(4, 9));
      cyc("rand");
    end
    idle();

    // asynchronous reset while a request is pending
    put_free(6); cyc("r0"); idle();
    put_free(7); cyc("r1"); idle();
    put_free(8); cyc("r2"); idle();
    put_iss(64'h100, 0, 64'h8); cyc("r3"); idle();
    cyc("r4");
    chk("r4", "mem_valid", mem_valid, 1);
    #2;
    rst_n = 0;
    #1;
    chk("arst", "mem_valid", mem_valid, 0);
    chk("arst", "count", count, 0);
    chk("arst", "mem_addr", mem_addr, 0);
    chk("arst", "mem_tag", mem_tag, 0);
    chk("arst", "iss_ready", iss_ready, 1);
    m_reset();
    @(posedge clk);
    #1;
    rst_n = 1;
    check_model("post_rst");
    put_iss(64'h40, 0, 64'h2); cyc("p0"); idle();
    cyc("p1");
    chk("p1", "mem_addr", mem_addr, 64'h42);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nfail);
    $finish;
  end

endmodule
